charbuf_reg_ctrl: RTL and testbench

//  Register block on the clk-domain side of the FSMC bus slave; drives the char_buf write port.
//  - Decodes do_write / w_adr / w_data into the character-buffer write port.
//  - Keeps the cursor address register and supports write-with-auto-increment.
//  - Runs a hardware fill (clear-screen) sequencer.
//  - Supplies read_data for the bus slave's read path: ADR and STATUS registers.

---
 rtl/charbuf_reg_ctrl_pkg.sv | 18 +
 rtl/charbuf_reg_ctrl_fill_seq.sv | 69 ++++++
 rtl/charbuf_reg_ctrl.sv | 112 +++++++++++
 tb/tb_charbuf_reg_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charbuf_reg_ctrl_pkg.sv
// Shared register map and fill-sequencer state encoding for the char_buf
// register block on the clk side of the FSMC slave.
package charbuf_reg_ctrl_pkg;

    // Bus register addresses
    localparam int unsigned REG_ADR      = 0;
    localparam int unsigned REG_STATUS   = 1;
    localparam int unsigned REG_DATA     = 2;
    localparam int unsigned REG_DATA_INC = 3;
    localparam int unsigned REG_FILL     = 4;

    // Fill sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/charbuf_reg_ctrl_fill_seq.sv
// Hardware fill (clear-screen) sequencer: once started, it presents one
// char_buf write per cycle for addresses 0..FILL_COUNT-1 with a fixed character.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no fill running; waits for start
//   ST_FILL | presenting write fill_cnt; leaves after FILL_COUNT-1
//
// we/adr/data are the write of the current cycle; the parent registers them
// onto cb_*, so the port write lands one edge later.
module charbuf_reg_ctrl_fill_seq
    import charbuf_reg_ctrl_pkg::*;
#(
    parameter int CB_AW      = 14,
    parameter int FILL_COUNT = 16384
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [7:0]       fill_ch_in,
    output logic             busy,
    output logic             we,
    output logic [CB_AW-1:0] adr,
    output logic [7:0]       data
);

    localparam logic [CB_AW-1:0] LAST_CNT = CB_AW'(FILL_COUNT - 1);

    fill_state_t      state;
    logic [CB_AW-1:0] fill_cnt;
    logic [7:0]       fill_ch;

    // Fill FSM, address counter and registered busy flag
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            fill_cnt <= '0;
            fill_ch  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        fill_ch  <= fill_ch_in;
                        fill_cnt <= '0;
                        state    <= ST_FILL;
                        busy     <= 1'b1;
                    end
                end
                ST_FILL: begin
                    fill_cnt <= fill_cnt + CB_AW'(1);
                    if (fill_cnt == LAST_CNT) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign we   = (state == ST_FILL);
    assign adr  = fill_cnt;
    assign data = fill_ch;

endmodule

// File: rtl/charbuf_reg_ctrl.sv
// Register block between the FSMC bus slave and the char_buf write port:
// cursor register with auto-increment, single-character writes, hardware
// fill, and the ADR/STATUS read path.
module charbuf_reg_ctrl
    import charbuf_reg_ctrl_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int CB_AW      = 14,
    parameter int FILL_COUNT = 16384
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             do_write,
    input  logic [AW-1:0]    w_adr,
    input  logic [DW-1:0]    w_data,
    input  logic             do_read,
    input  logic [AW-1:0]    r_adr,
    output logic [DW-1:0]    read_data,
    output logic             cb_we,
    output logic [CB_AW-1:0] cb_adr,
    output logic [7:0]       cb_data,
    output logic             busy
);

    logic [DW-1:0]    chadr;
    logic             drop;

    logic             seq_busy;
    logic             seq_we;
    logic [CB_AW-1:0] seq_adr;
    logic [7:0]       seq_data;

    logic hit_adr, hit_data, hit_data_inc, hit_fill, hit_port, status_rd;

    assign hit_adr      = do_write && (w_adr == AW'(REG_ADR));
    assign hit_data     = do_write && (w_adr == AW'(REG_DATA));
    assign hit_data_inc = do_write && (w_adr == AW'(REG_DATA_INC));
    assign hit_fill     = do_write && (w_adr == AW'(REG_FILL));
    // Writes that touch the char_buf port; refused while a fill owns it
    assign hit_port     = hit_data || hit_data_inc || hit_fill;
    assign status_rd    = do_read && (r_adr == AW'(REG_STATUS));

    charbuf_reg_ctrl_fill_seq #(
        .CB_AW      (CB_AW),
        .FILL_COUNT (FILL_COUNT)
    ) u_fill_seq (
        .clk        (clk),
        .nrst       (nrst),
        .start      (hit_fill && !seq_busy),
        .fill_ch_in (w_data[7:0]),
        .busy       (seq_busy),
        .we         (seq_we),
        .adr        (seq_adr),
        .data       (seq_data)
    );

    assign busy = seq_busy;

    // char_buf write port: fill sequencer has priority, else accepted DATA writes
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cb_we   <= 1'b0;
            cb_adr  <= '0;
            cb_data <= '0;
        end else begin
            cb_we <= 1'b0;
            if (seq_we) begin
                cb_we   <= 1'b1;
                cb_adr  <= seq_adr;
                cb_data <= seq_data;
            end else if (!seq_busy && (hit_data || hit_data_inc)) begin
                cb_we   <= 1'b1;
                cb_adr  <= chadr[CB_AW-1:0];
                cb_data <= w_data[7:0];
            end
        end
    end

    // Cursor register: ADR load always accepted, auto-increment only outside a fill
    always_ff @(posedge clk) begin
        if (!nrst) begin
            chadr <= '0;
        end else if (hit_adr) begin
            chadr <= w_data;
        end else if (hit_data_inc && !seq_busy) begin
            chadr <= chadr + DW'(1);
        end
    end

    // Sticky drop flag: set by refused port writes, cleared by a STATUS read (set wins)
    always_ff @(posedge clk) begin
        if (!nrst) begin
            drop <= 1'b0;
        end else if (seq_busy && hit_port) begin
            drop <= 1'b1;
        end else if (status_rd) begin
            drop <= 1'b0;
        end
    end

    // Combinational read mux; the bus slave samples it in the do_read cycle
    always_comb begin
        read_data = '0;
        case (r_adr)
            AW'(REG_ADR):    read_data = chadr;
            AW'(REG_STATUS): read_data = {{(DW-2){1'b0}}, drop, seq_busy};
            default:         read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_charbuf_reg_ctrl.sv
// Directed bench for charbuf_reg_ctrl with a 16-cell fill.
module tb_charbuf_reg_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int CB_AW = 14;
    localparam int FC    = 16;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             do_write = 1'b0;
    logic [AW-1:0]    w_adr = '0;
    logic [DW-1:0]    w_data = '0;
    logic             do_read = 1'b0;
    logic [AW-1:0]    r_adr = '0;
    logic [DW-1:0]    read_data;
    logic             cb_we;
    logic [CB_AW-1:0] cb_adr;
    logic [7:0]       cb_data;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    charbuf_reg_ctrl #(
        .AW(AW), .DW(DW), .CB_AW(CB_AW), .FILL_COUNT(FC)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .do_write  (do_write),
        .w_adr     (w_adr),
        .w_data    (w_data),
        .do_read   (do_read),
        .r_adr     (r_adr),
        .read_data (read_data),
        .cb_we     (cb_we),
        .cb_adr    (cb_adr),
        .cb_data   (cb_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        do_write = 1'b1;
        w_adr    = a;
        w_data   = d;
        @(posedge clk);
        #1;
        do_write = 1'b0;
        w_adr    = '0;
        w_data   = '0;
    endtask

    task automatic peek(input logic [AW-1:0] a, output logic [DW-1:0] v);
        r_adr = a;
        #1;
        v = read_data;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
        r_adr   = a;
        do_read = 1'b1;
        #1;
        v = read_data;
        @(posedge clk);
        #1;
        do_read = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        nrst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({cb_we, cb_adr, cb_data, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got we=%b adr=%h data=%h busy=%b, want all 0", cb_we, cb_adr, cb_data, busy);
        end
        nrst = 1'b1;
        rd(8'h00, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_err++; $display("FAIL reset_adr: got %h want 0000", v); end
        rd(8'h01, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_err++; $display("FAIL reset_status: got %h want 0000", v); end
    endtask

    task automatic test_data_write();
        logic [DW-1:0] v;
        wr(8'h00, 16'h0123);
        n_cmp++;
        if (cb_we !== 1'b0) begin n_err++; $display("FAIL adr_write_we: got %b want 0", cb_we); end
        wr(8'h02, 16'h0041);
        n_cmp++;
        if (cb_we !== 1'b1 || cb_adr !== 14'h0123 || cb_data !== 8'h41) begin
            n_err++;
            $display("FAIL data_write: got we=%b adr=%h data=%h want 1/0123/41", cb_we, cb_adr, cb_data);
        end
        tick();
        n_cmp++;
        if (cb_we !== 1'b0) begin n_err++; $display("FAIL data_we_pulse: got %b want 0", cb_we); end
        rd(8'h00, v);
        n_cmp++;
        if (v !== 16'h0123) begin n_err++; $display("FAIL data_chadr: got %h want 0123", v); end
    endtask

    task automatic test_back_to_back_inc();
        logic [DW-1:0]    v;
        logic [CB_AW-1:0] exp_adr [3];
        exp_adr = '{14'h3FFE, 14'h3FFF, 14'h0000};
        wr(8'h00, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            wr(8'h03, 16'h0061 + 16'(i));
            n_cmp++;
            if (cb_we !== 1'b1 || cb_adr !== exp_adr[i] || cb_data !== 8'(8'h61 + i)) begin
                n_err++;
                $display("FAIL inc_write_%0d: got we=%b adr=%h data=%h want 1/%h/%h", i, cb_we, cb_adr, cb_data, exp_adr[i], 8'(8'h61 + i));
            end
        end
        tick();
        n_cmp++;
        if (cb_we !== 1'b0) begin n_err++; $display("FAIL inc_we_end: got %b want 0", cb_we); end
        rd(8'h00, v);
        n_cmp++;
        if (v !== 16'h0001) begin n_err++; $display("FAIL inc_chadr_wrap: got %h want 0001", v); end
    endtask

    task automatic test_unmapped();
        logic [DW-1:0] v;
        wr(8'h07, 16'h00AA);
        n_cmp++;
        if (cb_we !== 1'b0) begin n_err++; $display("FAIL unmapped_we: got %b want 0", cb_we); end
        peek(8'h07, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_err++; $display("FAIL unmapped_read: got %h want 0000", v); end
        peek(8'h00, v);
        n_cmp++;
        if (v !== 16'h0001) begin n_err++; $display("FAIL unmapped_chadr: got %h want 0001", v); end
    endtask

    task automatic test_fill();
        logic [DW-1:0] v;
        int busy_cycles;
        wr(8'h04, 16'h0020);
        n_cmp++;
        if (busy !== 1'b1 || cb_we !== 1'b0) begin
            n_err++;
            $display("FAIL fill_start: got busy=%b we=%b want 1/0", busy, cb_we);
        end
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < FC; i++) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
            n_cmp++;
            if (cb_we !== 1'b1 || cb_adr !== 14'(i) || cb_data !== 8'h20) begin
                n_err++;
                $display("FAIL fill_cell_%0d: got we=%b adr=%h data=%h want 1/%h/20", i, cb_we, cb_adr, cb_data, 14'(i));
            end
        end
        n_cmp++;
        if (busy_cycles != FC || busy !== 1'b0) begin
            n_err++;
            $display("FAIL fill_busy_len: got %0d cycles (busy now %b) want %0d (0)", busy_cycles, busy, FC);
        end
        tick();
        n_cmp++;
        if (cb_we !== 1'b0) begin n_err++; $display("FAIL fill_we_end: got %b want 0", cb_we); end
        peek(8'h00, v);
        n_cmp++;
        if (v !== 16'h0001) begin n_err++; $display("FAIL fill_chadr: got %h want 0001", v); end
    endtask

    task automatic test_fill_drop();
        logic [DW-1:0] v;
        int n_we;
        logic bad;
        wr(8'h04, 16'h0033);
        wr(8'h02, 16'h0099);
        n_cmp++;
        if (cb_we !== 1'b1 || cb_adr !== 14'h0000 || cb_data !== 8'h33) begin
            n_err++;
            $display("FAIL drop_data: got we=%b adr=%h data=%h want 1/0000/33", cb_we, cb_adr, cb_data);
        end
        wr(8'h03, 16'h0098);
        n_cmp++;
        if (cb_adr !== 14'h0001 || cb_data !== 8'h33) begin
            n_err++;
            $display("FAIL drop_inc: got adr=%h data=%h want 0001/33", cb_adr, cb_data);
        end
        peek(8'h01, v);
        n_cmp++;
        if (v !== 16'h0003) begin n_err++; $display("FAIL drop_status: got %h want 0003", v); end
        wr(8'h00, 16'h0050);
        peek(8'h00, v);
        n_cmp++;
        if (v !== 16'h0050) begin n_err++; $display("FAIL drop_adr_accept: got %h want 0050", v); end
        wr(8'h04, 16'h0077);
        n_cmp++;
        if (cb_adr !== 14'h0003 || cb_data !== 8'h33) begin
            n_err++;
            $display("FAIL drop_refill: got adr=%h data=%h want 0003/33", cb_adr, cb_data);
        end
        n_we = 0;
        bad  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (cb_we !== 1'b1) break;
            if (cb_adr !== 14'(4 + n_we) || cb_data !== 8'h33) bad = 1'b1;
            n_we++;
        end
        n_cmp++;
        if (n_we != FC - 4 || bad || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drop_drain: got %0d writes bad=%b busy=%b want %0d/0/0", n_we, bad, busy, FC - 4);
        end
        peek(8'h00, v);
        n_cmp++;
        if (v !== 16'h0050) begin n_err++; $display("FAIL drop_chadr_kept: got %h want 0050", v); end
        rd(8'h01, v);
        n_cmp++;
        if (v !== 16'h0002) begin n_err++; $display("FAIL drop_sticky: got %h want 0002", v); end
        rd(8'h01, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_err++; $display("FAIL drop_cleared: got %h want 0000", v); end
    endtask

    task automatic test_reset_mid_fill();
        logic [DW-1:0] v;
        int n_we;
        logic bad;
        wr(8'h04, 16'h0044);
        for (int i = 0; i < 4; i++) tick();
        // drop event and STATUS read on the same edge
        do_write = 1'b1; w_adr = 8'h02; w_data = 16'h0011;
        do_read  = 1'b1; r_adr = 8'h01;
        tick();
        do_write = 1'b0; w_adr = '0; w_data = '0; do_read = 1'b0;
        n_cmp++;
        if (cb_adr !== 14'h0004 || cb_data !== 8'h44) begin
            n_err++;
            $display("FAIL rst_pre_count: got adr=%h data=%h want 0004/44", cb_adr, cb_data);
        end
        peek(8'h01, v);
        n_cmp++;
        if (v !== 16'h0003) begin n_err++; $display("FAIL drop_set_wins: got %h want 0003", v); end
        nrst = 1'b0;
        tick();
        n_cmp++;
        if (cb_we !== 1'b0 || busy !== 1'b0 || cb_adr !== 14'h0000) begin
            n_err++;
            $display("FAIL rst_abort: got we=%b busy=%b adr=%h want 0/0/0000", cb_we, busy, cb_adr);
        end
        peek(8'h01, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_err++; $display("FAIL rst_status: got %h want 0000", v); end
        nrst = 1'b1;
        wr(8'h04, 16'h0055);
        tick();
        n_cmp++;
        if (cb_we !== 1'b1 || cb_adr !== 14'h0000 || cb_data !== 8'h55) begin
            n_err++;
            $display("FAIL refill_first: got we=%b adr=%h data=%h want 1/0000/55", cb_we, cb_adr, cb_data);
        end
        n_we = 1;
        bad  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (cb_we !== 1'b1) break;
            if (cb_adr !== 14'(n_we) || cb_data !== 8'h55) bad = 1'b1;
            n_we++;
        end
        n_cmp++;
        if (n_we != FC || bad || busy !== 1'b0) begin
            n_err++;
            $display("FAIL refill_drain: got %0d writes bad=%b busy=%b want %0d/0/0", n_we, bad, busy, FC);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_data_write();
        test_back_to_back_inc();
        test_unmapped();
        test_fill();
        test_fill_drop();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
